// File: rtl/tds_column_feeder.sv
// Column feeder for the ternary data sorter: buffers two image lines and emits vertical
// 3-pixel columns. Optional border replication is enabled with TDS_BORDER_REPLICATE_EN.
module tds_column_feeder #(
    parameter int unsigned DW    = 8,
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DW-1:0]            s_pix,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DW-1:0]            m_p0,
    output logic [DW-1:0]            m_p1,
    output logic [DW-1:0]            m_p2,
    output logic [$clog2(IMG_W)-1:0] m_col,
    output logic                     m_last
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    logic [DW-1:0] r_lb0 [IMG_W];
    logic [DW-1:0] r_lb1 [IMG_W];

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_m_valid;
    logic [DW-1:0] r_m_p0;
    logic [DW-1:0] r_m_p1;
    logic [DW-1:0] r_m_p2;
    logic [CW-1:0] r_m_col;
    logic          r_m_last;

    logic          w_accept;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_emit;
    logic [DW-1:0] w_rd0;
    logic [DW-1:0] w_rd1;
    logic [DW-1:0] w_p0;
    logic [DW-1:0] w_p1;

    // Single output stage: a new pixel fits whenever the held triple leaves this cycle.
    assign s_ready    = !rst && (!r_m_valid || m_ready);
    assign w_accept   = s_valid && s_ready;
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    assign w_rd0      = r_lb0[r_col];
    assign w_rd1      = r_lb1[r_col];

`ifdef TDS_BORDER_REPLICATE_EN
    // Top rows replicate the nearest real line instead of being suppressed.
    assign w_emit = 1'b1;
    assign w_p0   = (r_row == RW'(0)) ? s_pix : ((r_row == RW'(1)) ? w_rd1 : w_rd0);
    assign w_p1   = (r_row == RW'(0)) ? s_pix : w_rd1;
`else
    assign w_emit = (r_row >= RW'(2));
    assign w_p0   = w_rd0;
    assign w_p1   = w_rd1;
`endif

    // Line buffers shift one line down per accepted pixel; contents are never reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0[r_col] <= w_rd1;
            r_lb1[r_col] <= s_pix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col     <= '0;
            r_row     <= '0;
            r_m_valid <= 1'b0;
            r_m_p0    <= '0;
            r_m_p1    <= '0;
            r_m_p2    <= '0;
            r_m_col   <= '0;
            r_m_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                r_m_valid <= w_emit;
                if (w_emit) begin
                    r_m_p0   <= w_p0;
                    r_m_p1   <= w_p1;
                    r_m_p2   <= s_pix;
                    r_m_col  <= r_col;
                    r_m_last <= w_col_last && w_row_last;
                end
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_p0    = r_m_p0;
    assign m_p1    = r_m_p1;
    assign m_p2    = r_m_p2;
    assign m_col   = r_m_col;
    assign m_last  = r_m_last;

endmodule

// File: tb/tb_tds_column_feeder.sv
// Self-checking bench for tds_column_feeder on a 4x4 image with pixel = 16*row+col.
// A cycle model tracks m_valid/s_ready; a scoreboard queue holds expected triples.
module tb_tds_column_feeder;

    localparam int W = 4;
    localparam int H = 4;
`ifdef TDS_BORDER_REPLICATE_EN
    localparam int PER_FRAME = W * H;
`else
    localparam int PER_FRAME = W * (H - 2);
`endif

    typedef struct packed {
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] p2;
        logic [1:0] col;
        logic       last;
    } trip_t;

    typedef struct {
        int    idx;
        trip_t t;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_pix;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_p0;
    logic [7:0] m_p1;
    logic [7:0] m_p2;
    logic [1:0] m_col;
    logic       m_last;

    tds_column_feeder #(.DW(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_pix  (s_pix),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_p0   (m_p0),
        .m_p1   (m_p1),
        .m_p2   (m_p2),
        .m_col  (m_col),
        .m_last (m_last)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    trip_t sb[$];
    trip_t cap[$];
    vec_t  tbl[4];
    int    mr = 0, mc = 0;
    int    dr = 0, dc = 0;
    bit    exp_v = 1'b0;
    bit    prev_hold = 1'b0;
    trip_t prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mk_emit(input int r);
`ifdef TDS_BORDER_REPLICATE_EN
        return 1'b1;
`else
        return r >= 2;
`endif
    endfunction

    function automatic trip_t mk_trip(input int r, input int c);
        trip_t t;
        t.p2   = 8'(16 * r + c);
        t.p1   = (r >= 1) ? 8'(16 * (r - 1) + c) : t.p2;
        t.p0   = (r >= 2) ? 8'(16 * (r - 2) + c) : t.p1;
        t.col  = 2'(c);
        t.last = (r == H - 1) && (c == W - 1);
        return t;
    endfunction

    // Cycle model and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        trip_t act;
        act = {m_p0, m_p1, m_p2, m_col, m_last};
        if (rst) begin
            check("rst_m_valid", 32'(m_valid), 32'(0));
            check("rst_s_ready", 32'(s_ready), 32'(0));
            sb.delete();
            mr = 0; mc = 0; exp_v = 1'b0; prev_hold = 1'b0;
        end else begin
            check("s_ready", 32'(s_ready), 32'(!exp_v || m_ready));
            check("m_valid", 32'(m_valid), 32'(exp_v));
            if (m_valid) begin
                if (sb.size() == 0) check("sb_empty", 32'(1), 32'(0));
                else check("triple", 32'(act), 32'(sb[0]));
                if (prev_hold) check("hold_stable", 32'(act), 32'(prev));
            end
            prev_hold = m_valid && !m_ready;
            prev = act;
            if (m_valid && m_ready) begin
                cap.push_back(act);
                if (sb.size() > 0) void'(sb.pop_front());
            end
            if (s_valid && s_ready) begin
                exp_v = mk_emit(mr);
                if (exp_v) sb.push_back(mk_trip(mr, mc));
                if (mc == W - 1) begin
                    mc = 0;
                    mr = (mr == H - 1) ? 0 : mr + 1;
                end else begin
                    mc++;
                end
            end else if (m_valid && m_ready) begin
                exp_v = 1'b0;
            end
        end
    end

    task automatic send(input int npix, input bit gap);
        for (int i = 0; i < npix; i++) begin
            int n;
            s_pix   = 8'(16 * dr + dc);
            s_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!s_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) check("accept_timeout", 32'(n), 32'(0));
            @(posedge clk); #1;
            if (dc == W - 1) begin
                dc = 0;
                dr = (dr == H - 1) ? 0 : dr + 1;
            end else begin
                dc++;
            end
            if (gap) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst     = 1'b1;
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        dr  = 0;
        dc  = 0;
    endtask

    task automatic drain_and_check(input string name, input int n_exp);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_sb_drained"}, 32'(sb.size()), 32'(0));
        check({name, "_count"}, 32'(cap.size()), 32'(n_exp));
    endtask

    task automatic tbl_check(input string name, input int base);
        for (int i = 0; i < 4; i++) begin
            if (base + tbl[i].idx < cap.size())
                check(name, 32'(cap[base + tbl[i].idx]), 32'(tbl[i].t));
            else
                check({name, "_missing"}, 32'(cap.size()), 32'(base + tbl[i].idx + 1));
        end
    endtask

    initial begin
`ifdef TDS_BORDER_REPLICATE_EN
        tbl[0] = '{0,  '{8'h00, 8'h00, 8'h00, 2'd0, 1'b0}};
        tbl[1] = '{4,  '{8'h00, 8'h00, 8'h10, 2'd0, 1'b0}};
        tbl[2] = '{8,  '{8'h00, 8'h10, 8'h20, 2'd0, 1'b0}};
        tbl[3] = '{15, '{8'h13, 8'h23, 8'h33, 2'd3, 1'b1}};
`else
        tbl[0] = '{0, '{8'h00, 8'h10, 8'h20, 2'd0, 1'b0}};
        tbl[1] = '{3, '{8'h03, 8'h13, 8'h23, 2'd3, 1'b0}};
        tbl[2] = '{4, '{8'h10, 8'h20, 8'h30, 2'd0, 1'b0}};
        tbl[3] = '{7, '{8'h13, 8'h23, 8'h33, 2'd3, 1'b1}};
`endif
        rst     = 1'b1;
        s_valid = 1'b0;
        s_pix   = 8'h00;
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out", 32'({m_p0, m_p1, m_p2, m_col, m_last}), 32'(0));
        do_reset();

        // Full frame at full rate
        cap.delete();
        send(W * H, 1'b0);
        drain_and_check("frame", PER_FRAME);
        tbl_check("frame_tbl", 0);

        // Two frames back to back
        cap.delete();
        send(2 * W * H, 1'b0);
        drain_and_check("b2b", 2 * PER_FRAME);
        tbl_check("b2b_tbl", PER_FRAME);

        // Sorter stalls for 5 cycles in the middle of row 2
        cap.delete();
        fork
            send(W * H, 1'b0);
            begin
                int n;
                n = 0;
                while (!(mr == 2 && mc == 1) && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 100) check("stall_sync_timeout", 32'(n), 32'(0));
                @(posedge clk); #1;
                m_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                m_ready = 1'b1;
            end
        join
        drain_and_check("stall", PER_FRAME);
        tbl_check("stall_tbl", 0);

        // Input valid toggling every cycle
        cap.delete();
        send(W * H, 1'b1);
        drain_and_check("gap", PER_FRAME);
        tbl_check("gap_tbl", 0);

        // Reset in the middle of a frame, then a clean frame
        send(9, 1'b0);
        do_reset();
        cap.delete();
        send(W * H, 1'b0);
        drain_and_check("rst_mid", PER_FRAME);
        tbl_check("rst_mid_tbl", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
